// File: rtl/rv32i_decode_execute.sv
// RV32I single-cycle decode/execute slice: control decoder, ALU, branch
// comparator and the PC register with next-PC selection.
module rv32i_decode_execute #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iInitialPC,
    input  logic [31:0] iInstr,
    input  logic [31:0] iRead1,
    input  logic [31:0] iRead2,
    input  logic [31:0] iImm,
    output logic [31:0] oPC,
    output logic [31:0] oPC4,
    output logic [31:0] oNextPC,
    output logic [31:0] oALUResult,
    output logic        oZero,
    output logic        oBranch,
    output logic        oRegWrite,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic [1:0]  oMem2Reg,
    output logic [1:0]  oOrigPC,
    output logic [4:0]  oALUControl
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned ALUW = 5;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALUW-1:0] ALU_AND  = ALUW'(0);
    localparam logic [ALUW-1:0] ALU_OR   = ALUW'(1);
    localparam logic [ALUW-1:0] ALU_XOR  = ALUW'(2);
    localparam logic [ALUW-1:0] ALU_ADD  = ALUW'(3);
    localparam logic [ALUW-1:0] ALU_SUB  = ALUW'(4);
    localparam logic [ALUW-1:0] ALU_SLT  = ALUW'(5);
    localparam logic [ALUW-1:0] ALU_SLTU = ALUW'(6);
    localparam logic [ALUW-1:0] ALU_SLL  = ALUW'(7);
    localparam logic [ALUW-1:0] ALU_SRL  = ALUW'(8);
    localparam logic [ALUW-1:0] ALU_SRA  = ALUW'(9);
    localparam logic [ALUW-1:0] ALU_LUI  = ALUW'(10);

    logic [XLEN-1:0] pc_q = RESET_PC;
    logic [XLEN-1:0] pc_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            src_pc;
    logic            src_imm;
    logic [ALUW-1:0] alu_ctrl;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] jalr_tgt;
    logic            branch_c;
    logic            unused_instr;

    assign opcode       = iInstr[6:0];
    assign funct3       = iInstr[14:12];
    assign funct7b5     = iInstr[30];
    assign unused_instr = ^{iInstr[31], iInstr[29:15], iInstr[11:7]};

    // Shared R-type / OP-IMM mapping; only the register form may subtract.
    function automatic logic [ALUW-1:0] alu_from_funct(input logic [2:0] f3,
                                                       input logic       alt,
                                                       input logic       is_reg);
        case (f3)
            3'b000:  return (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Main control decoder
    always_comb begin
        oRegWrite = 1'b0;
        oMemRead  = 1'b0;
        oMemWrite = 1'b0;
        oMem2Reg  = 2'b00;
        oOrigPC   = 2'b00;
        alu_ctrl  = ALU_ADD;
        src_pc    = 1'b0;
        src_imm   = 1'b1;
        case (opcode)
            OP_REG: begin
                oRegWrite = 1'b1;
                src_imm   = 1'b0;
                alu_ctrl  = alu_from_funct(funct3, funct7b5, 1'b1);
            end
            OP_IMM: begin
                oRegWrite = 1'b1;
                alu_ctrl  = alu_from_funct(funct3, funct7b5, 1'b0);
            end
            OP_LOAD: begin
                oRegWrite = 1'b1;
                oMemRead  = 1'b1;
                oMem2Reg  = 2'b10;
            end
            OP_STORE: oMemWrite = 1'b1;
            OP_BRANCH: begin
                oOrigPC  = 2'b01;
                alu_ctrl = ALU_SUB;
                src_imm  = 1'b0;
            end
            OP_JAL: begin
                oRegWrite = 1'b1;
                oMem2Reg  = 2'b01;
                oOrigPC   = 2'b10;
            end
            OP_JALR: begin
                oRegWrite = 1'b1;
                oMem2Reg  = 2'b01;
                oOrigPC   = 2'b11;
            end
            OP_LUI: begin
                oRegWrite = 1'b1;
                alu_ctrl  = ALU_LUI;
            end
            OP_AUIPC: begin
                oRegWrite = 1'b1;
                src_pc    = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_a = src_pc  ? pc_q : iRead1;
    assign alu_b = src_imm ? iImm : iRead2;

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_AND:  alu_res = alu_a & alu_b;
            ALU_OR:   alu_res = alu_a | alu_b;
            ALU_XOR:  alu_res = alu_a ^ alu_b;
            ALU_ADD:  alu_res = alu_a + alu_b;
            ALU_SUB:  alu_res = alu_a - alu_b;
            ALU_SLT:  alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
            ALU_SLTU: alu_res = XLEN'(alu_a < alu_b);
            ALU_SLL:  alu_res = alu_a << alu_b[4:0];
            ALU_SRL:  alu_res = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_res = XLEN'($signed(alu_a) >>> alu_b[4:0]);
            ALU_LUI:  alu_res = alu_b;
            default:  alu_res = '0;
        endcase
    end

    // Branch condition always compares the raw register operands
    always_comb begin
        branch_c = 1'b0;
        case (funct3)
            3'b000:  branch_c = (iRead1 == iRead2);
            3'b001:  branch_c = (iRead1 != iRead2);
            3'b100:  branch_c = ($signed(iRead1) <  $signed(iRead2));
            3'b101:  branch_c = ($signed(iRead1) >= $signed(iRead2));
            3'b110:  branch_c = (iRead1 <  iRead2);
            3'b111:  branch_c = (iRead1 >= iRead2);
            default: branch_c = 1'b0;
        endcase
    end

    assign pc4      = pc_q + XLEN'(4);
    assign pc_rel   = pc_q + iImm;
    assign jalr_tgt = (iRead1 + iImm) & ~XLEN'(1);

    always_comb begin
        pc_d = pc4;
        case (oOrigPC)
            2'b01:   pc_d = branch_c ? pc_rel : pc4;
            2'b10:   pc_d = pc_rel;
            2'b11:   pc_d = jalr_tgt;
            default: pc_d = pc4;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) pc_q <= iInitialPC;
        else      pc_q <= pc_d;
    end

    assign oPC         = pc_q;
    assign oPC4        = pc4;
    assign oNextPC     = pc_d;
    assign oALUResult  = alu_res;
    assign oZero       = (alu_res == '0);
    assign oBranch     = branch_c;
    assign oALUControl = alu_ctrl;

endmodule

// File: tb/tb_rv32i_decode_execute.sv
// Self-checking bench for rv32i_decode_execute: directed vector table,
// reset/PC sequences and randomized instructions against an ISA-level model.
module tb_rv32i_decode_execute;
    logic        iCLK = 1'b0;
    logic        iRST;
    logic [31:0] iInitialPC, iInstr, iRead1, iRead2, iImm;
    logic [31:0] oPC, oPC4, oNextPC, oALUResult;
    logic        oZero, oBranch, oRegWrite, oMemRead, oMemWrite;
    logic [1:0]  oMem2Reg, oOrigPC;
    logic [4:0]  oALUControl;

    int n_cmp  = 0;
    int n_fail = 0;

    rv32i_decode_execute #(.RESET_PC(32'h0040_0000)) dut (
        .iCLK(iCLK), .iRST(iRST), .iInitialPC(iInitialPC), .iInstr(iInstr),
        .iRead1(iRead1), .iRead2(iRead2), .iImm(iImm),
        .oPC(oPC), .oPC4(oPC4), .oNextPC(oNextPC), .oALUResult(oALUResult),
        .oZero(oZero), .oBranch(oBranch), .oRegWrite(oRegWrite),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oMem2Reg(oMem2Reg),
        .oOrigPC(oOrigPC), .oALUControl(oALUControl)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [31:0] pc, instr, r1, r2, imm, res, nxt;
        logic        zero, br, rw, mr, mw;
        logic [1:0]  m2r, opc;
    } vec_t;

    typedef struct {
        logic [31:0] res, nxt;
        logic        zero, br, rw, mr, mw;
        logic [1:0]  m2r, opc;
        logic [4:0]  aluc;
    } exp_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // {alu code, result} of an RV32I register/immediate arithmetic op
    function automatic logic [36:0] isa_alu(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return alt ? {5'd4, a - b} : {5'd3, a + b};
            3'd1:    return {5'd7, a << b[4:0]};
            3'd2:    return {5'd5, 32'($signed(a) < $signed(b))};
            3'd3:    return {5'd6, 32'(a < b)};
            3'd4:    return {5'd2, a ^ b};
            3'd5:    return alt ? {5'd9, 32'($signed(a) >>> b[4:0])} : {5'd8, a >> b[4:0]};
            3'd6:    return {5'd1, a | b};
            default: return {5'd0, a & b};
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] instr,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm);
        exp_t e;
        logic [2:0]  f3;
        logic [36:0] r;
        f3 = instr[14:12];
        e = '{res: a + imm, nxt: pc + 32'd4, zero: 1'b0, br: 1'b0, rw: 1'b0, mr: 1'b0,
              mw: 1'b0, m2r: 2'd0, opc: 2'd0, aluc: 5'd3};
        case (instr[6:0])
            7'h33: begin e.rw = 1; r = isa_alu(f3, instr[30], a, b); {e.aluc, e.res} = r; end
            7'h13: begin e.rw = 1; r = isa_alu(f3, instr[30] && f3 == 3'd5, a, imm); {e.aluc, e.res} = r; end
            7'h03: begin e.rw = 1; e.mr = 1; e.m2r = 2'd2; end
            7'h23: e.mw = 1;
            7'h63: begin e.opc = 2'd1; e.aluc = 5'd4; e.res = a - b; end
            7'h6F: begin e.rw = 1; e.m2r = 2'd1; e.opc = 2'd2; end
            7'h67: begin e.rw = 1; e.m2r = 2'd1; e.opc = 2'd3; end
            7'h37: begin e.rw = 1; e.aluc = 5'd10; e.res = imm; end
            7'h17: begin e.rw = 1; e.res = pc + imm; end
            default: ;
        endcase
        case (f3)
            3'd0: e.br = (a == b);
            3'd1: e.br = (a != b);
            3'd4: e.br = ($signed(a) <  $signed(b));
            3'd5: e.br = ($signed(a) >= $signed(b));
            3'd6: e.br = (a <  b);
            3'd7: e.br = (a >= b);
            default: e.br = 1'b0;
        endcase
        case (e.opc)
            2'd1: if (e.br) e.nxt = pc + imm;
            2'd2: e.nxt = pc + imm;
            2'd3: e.nxt = (a + imm) & 32'hFFFF_FFFE;
            default: ;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic apply_reset(input logic [31:0] pc);
        iRST = 1'b1;
        iInitialPC = pc;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        iInstr = instr; iRead1 = a; iRead2 = b; iImm = imm;
    endtask

    task automatic check_model(input string tag, input exp_t e);
        check({tag, ".res"},  oALUResult, e.res);
        check({tag, ".next"}, oNextPC, e.nxt);
        check({tag, ".zero"}, {31'b0, oZero}, {31'b0, e.zero});
        check({tag, ".br"},   {31'b0, oBranch}, {31'b0, e.br});
        check({tag, ".ctl"},  {20'b0, oRegWrite, oMemRead, oMemWrite, oMem2Reg, oOrigPC, oALUControl},
                              {20'b0, e.rw, e.mr, e.mw, e.m2r, e.opc, e.aluc});
    endtask

    vec_t tv[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [31:0] mpc;
        logic [6:0]  ops[10];
        iRST = 1'b0; iInitialPC = 32'h0050_0000;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        check("powerup_pc", oPC, 32'h0040_0000);

        // addi x1,x0,5 stepping from reset
        drive(32'h0050_0093, 32'h0, 32'h0, 32'd5);
        apply_reset(32'h0040_0000);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("addi%0d.pc", k), oPC, 32'h0040_0000 + 32'(4 * k));
            check($sformatf("addi%0d.res", k), oALUResult, 32'd5);
            check($sformatf("addi%0d.rw_m2r", k), {29'b0, oRegWrite, oMem2Reg}, {29'b0, 1'b1, 2'b00});
            @(posedge iCLK);
            #1;
        end

        //        pc            instr         r1            r2            imm           res           next          z  br rw mr mw m2r opc
        tv[0]  = '{32'h00400000, 32'h402081B3, 32'h80000000, 32'h00000001, 32'h0,        32'h7FFFFFFF, 32'h00400004, 0, 0, 1, 0, 0, 0, 0};
        tv[1]  = '{32'h00400000, 32'h0020A1B3, 32'h80000000, 32'h00000001, 32'h0,        32'h00000001, 32'h00400004, 0, 0, 1, 0, 0, 0, 0};
        tv[2]  = '{32'h00400000, 32'h0020B1B3, 32'h80000000, 32'h00000001, 32'h0,        32'h00000000, 32'h00400004, 1, 0, 1, 0, 0, 0, 0};
        tv[3]  = '{32'h00400000, 32'h4020D1B3, 32'hF0000000, 32'h00000004, 32'h0,        32'hFF000000, 32'h00400004, 0, 0, 1, 0, 0, 0, 0};
        tv[4]  = '{32'h00400000, 32'h0020D1B3, 32'hF0000000, 32'h00000004, 32'h0,        32'h0F000000, 32'h00400004, 0, 0, 1, 0, 0, 0, 0};
        tv[5]  = '{32'h00400000, 32'h402081B3, 32'h00001234, 32'h00001234, 32'h0,        32'h00000000, 32'h00400004, 1, 1, 1, 0, 0, 0, 0};
        tv[6]  = '{32'h00400010, 32'h00208063, 32'h00000007, 32'h00000007, 32'hFFFFFFF8, 32'h00000000, 32'h00400008, 1, 1, 0, 0, 0, 0, 1};
        tv[7]  = '{32'h00400010, 32'h0020C063, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'h00400008, 0, 1, 0, 0, 0, 0, 1};
        tv[8]  = '{32'h00400010, 32'h0020E063, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'h00400014, 0, 0, 0, 0, 0, 0, 1};
        tv[9]  = '{32'h00400000, 32'h000080E7, 32'h00400103, 32'h00000000, 32'h0,        32'h00400103, 32'h00400102, 0, 0, 1, 0, 0, 1, 3};
        tv[10] = '{32'h00400000, 32'h010000EF, 32'h00000000, 32'h00000000, 32'h10,       32'h00000010, 32'h00400010, 0, 1, 1, 0, 0, 1, 2};
        tv[11] = '{32'h00400000, 32'h0020A223, 32'h00001000, 32'h0000DEAD, 32'h4,        32'h00001004, 32'h00400004, 0, 0, 0, 0, 1, 0, 0};
        tv[12] = '{32'h00400000, 32'h0040A183, 32'h00002000, 32'h00000000, 32'h8,        32'h00002008, 32'h00400004, 0, 0, 1, 1, 0, 2, 0};
        tv[13] = '{32'h00400000, 32'h00000000, 32'h00000005, 32'h00000006, 32'h7,        32'h0000000C, 32'h00400004, 0, 0, 0, 0, 0, 0, 0};
        tv[14] = '{32'h00400000, 32'h123450B7, 32'h00000000, 32'h00000000, 32'h12345000, 32'h12345000, 32'h00400004, 0, 1, 1, 0, 0, 0, 0};
        tv[15] = '{32'h00400000, 32'h00001097, 32'h00000000, 32'h00000000, 32'h1000,     32'h00401000, 32'h00400004, 0, 0, 1, 0, 0, 0, 0};
        tv[16] = '{32'h00400000, 32'hC0000093, 32'h0000000A, 32'h00000000, 32'hFFFFFC00, 32'hFFFFFC0A, 32'h00400004, 0, 0, 1, 0, 0, 0, 0};
        tv[17] = '{32'h00400000, 32'h4010D093, 32'h80000000, 32'h00000000, 32'h401,      32'hC0000000, 32'h00400004, 0, 0, 1, 0, 0, 0, 0};
        tv[18] = '{32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0,        32'h00000000, 32'h00000000, 1, 1, 0, 0, 0, 0, 0};

        foreach (tv[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            apply_reset(tv[i].pc);
            drive(tv[i].instr, tv[i].r1, tv[i].r2, tv[i].imm);
            #1;
            check({t, ".pc"},   oPC, tv[i].pc);
            check({t, ".pc4"},  oPC4, tv[i].pc + 32'd4);
            check({t, ".res"},  oALUResult, tv[i].res);
            check({t, ".next"}, oNextPC, tv[i].nxt);
            check({t, ".flags"}, {27'b0, oZero, oBranch, oRegWrite, oMemRead, oMemWrite},
                                 {27'b0, tv[i].zero, tv[i].br, tv[i].rw, tv[i].mr, tv[i].mw});
            check({t, ".sel"},  {28'b0, oMem2Reg, oOrigPC}, {28'b0, tv[i].m2r, tv[i].opc});
            e = model(tv[i].pc, tv[i].instr, tv[i].r1, tv[i].r2, tv[i].imm);
            check({t, ".aluc"}, {27'b0, oALUControl}, {27'b0, e.aluc});
        end

        // Reset wins over a decoded jal; reset is sampled only on edges
        apply_reset(32'h0040_0000);
        drive(32'h010000EF, 32'h0, 32'h0, 32'h10);
        iInitialPC = 32'h0050_0000;
        #1;
        check("rstjal.next", oNextPC, 32'h0040_0010);
        iRST = 1'b1;
        #1;
        check("rstjal.sync_pc", oPC, 32'h0040_0000);
        @(posedge iCLK);
        #1;
        check("rstjal.pc", oPC, 32'h0050_0000);
        iRST = 1'b0;
        #1;
        check("rstjal.hold_pc", oPC, 32'h0050_0000);
        @(posedge iCLK);
        #1;
        check("rstjal.jump_pc", oPC, 32'h0050_0010);

        // Randomized free-running instruction stream
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0B};
        mpc = 32'h0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] instr, a, b, imm;
            if (i % 16 == 0) begin
                mpc = $urandom;
                apply_reset(mpc);
            end
            instr = $urandom;
            instr[6:0] = ops[$urandom_range(0, 9)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 4095)) - 2048);
            drive(instr, a, b, imm);
            #1;
            e = model(mpc, instr, a, b, imm);
            check($sformatf("rnd%0d.pc4", i), oPC4, mpc + 32'd4);
            check_model($sformatf("rnd%0d", i), e);
            @(posedge iCLK);
            #1;
            check($sformatf("rnd%0d.pc", i), oPC, e.nxt);
            mpc = e.nxt;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
